// File: rtl/iomem_gpio_bank.sv
// rtl/iomem_gpio_bank.sv - WIDTH-channel GPIO slave on the picorv32 iomem bus
module iomem_gpio_bank #(
    parameter int              WIDTH     = 8,
    parameter logic [31:0]     BASE_ADDR = 32'h0300_0000,
    parameter logic [WIDTH-1:0] OUT_RESET = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             iomem_valid,
    output logic             iomem_ready,
    input  logic [3:0]       iomem_wstrb,
    input  logic [31:0]      iomem_addr,
    input  logic [31:0]      iomem_wdata,
    output logic [31:0]      iomem_rdata,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);

    localparam logic [5:0] REG_OUT    = 6'd0;
    localparam logic [5:0] REG_DIR    = 6'd1;
    localparam logic [5:0] REG_IN     = 6'd2;
    localparam logic [5:0] REG_SET    = 6'd3;
    localparam logic [5:0] REG_CLR    = 6'd4;
    localparam logic [5:0] REG_TOG    = 6'd5;
    localparam logic [5:0] REG_MASK   = 6'd6;
    localparam logic [5:0] REG_STATUS = 6'd7;
    localparam logic [5:0] REG_EDGE   = 6'd8;

    logic [WIDTH-1:0] out_r, dir_r, mask_r, status_r, edge_sel;
    logic [WIDTH-1:0] out_next, dir_next, mask_next, status_next, edge_next;
    logic [WIDTH-1:0] s1, s2, s3;
    logic [WIDTH-1:0] edge_evt, wm, wd;
    logic [31:0]      bmask, rd_word;
    logic [5:0]       word;
    logic             hit, access, wr;
    logic             unused_bits;

    assign unused_bits = ^{iomem_addr[1:0], iomem_wdata, bmask};

    always_comb begin
        hit    = iomem_valid && (iomem_addr[31:8] == BASE_ADDR[31:8]);
        access = hit && !iomem_ready;
        wr     = access && (|iomem_wstrb);
        word   = iomem_addr[7:2];
        bmask  = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}},
                  {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};
        wm     = bmask[WIDTH-1:0];
        wd     = iomem_wdata[WIDTH-1:0] & wm;
        // s3 is one cycle older than s2, so the pair shows a clean transition
        edge_evt = (edge_sel & s3 & ~s2) | (~edge_sel & ~s3 & s2);
    end

    always_comb begin
        out_next    = out_r;
        dir_next    = dir_r;
        mask_next   = mask_r;
        edge_next   = edge_sel;
        status_next = status_r;
        if (wr) begin
            case (word)
                REG_OUT:    out_next    = (out_r & ~wm) | wd;
                REG_DIR:    dir_next    = (dir_r & ~wm) | wd;
                REG_SET:    out_next    = out_r | wd;
                REG_CLR:    out_next    = out_r & ~wd;
                REG_TOG:    out_next    = out_r ^ wd;
                REG_MASK:   mask_next   = (mask_r & ~wm) | wd;
                REG_STATUS: status_next = status_r & ~wd;
                REG_EDGE:   edge_next   = (edge_sel & ~wm) | wd;
                default:    ;
            endcase
        end
        // Applied after the W1C so a fresh edge beats a same-cycle clear
        status_next = status_next | edge_evt;
    end

    always_comb begin
        rd_word = '0;
        case (word)
            REG_OUT:    rd_word[WIDTH-1:0] = out_r;
            REG_DIR:    rd_word[WIDTH-1:0] = dir_r;
            REG_IN:     rd_word[WIDTH-1:0] = s2;
            REG_MASK:   rd_word[WIDTH-1:0] = mask_r;
            REG_STATUS: rd_word[WIDTH-1:0] = status_r;
            REG_EDGE:   rd_word[WIDTH-1:0] = edge_sel;
            default:    rd_word = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            iomem_ready <= 1'b0;
            iomem_rdata <= '0;
            out_r       <= OUT_RESET;
            dir_r       <= '0;
            mask_r      <= '0;
            status_r    <= '0;
            edge_sel    <= '0;
            s1          <= '0;
            s2          <= '0;
            s3          <= '0;
        end else begin
            iomem_ready <= access;
            iomem_rdata <= access ? rd_word : 32'd0;
            out_r       <= out_next;
            dir_r       <= dir_next;
            mask_r      <= mask_next;
            status_r    <= status_next;
            edge_sel    <= edge_next;
            s1          <= gpio_in;
            s2          <= s1;
            s3          <= s2;
        end
    end

    assign gpio_out = out_r;
    assign gpio_oe  = dir_r;
    assign irq      = |(status_r & mask_r);

endmodule

// File: tb/tb_iomem_gpio_bank.sv
// tb/tb_iomem_gpio_bank.sv - directed-vector bench for iomem_gpio_bank
module tb_iomem_gpio_bank;

    localparam logic [31:0] BASE = 32'h0300_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;
    logic [7:0]  gpio_in;
    logic [7:0]  gpio_out;
    logic [7:0]  gpio_oe;
    logic        irq;

    int nvec = 0;
    int nmis = 0;

    iomem_gpio_bank #(.WIDTH(8), .BASE_ADDR(BASE), .OUT_RESET(8'h00)) dut (
        .clk(clk), .reset(reset),
        .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
        .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr),
        .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
        .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction, checking that ready lasts a single cycle
    task automatic bus(input logic [7:0] off, input logic [3:0] strb,
                       input logic [31:0] wd, output logic [31:0] rd);
        bit acked = 0;
        rd = '0;
        iomem_valid = 1'b1;
        iomem_addr  = BASE + {24'd0, off};
        iomem_wstrb = strb;
        iomem_wdata = wd;
        for (int i = 0; i < 4 && !acked; i++) begin
            tick();
            if (iomem_ready) begin
                acked = 1;
                rd = iomem_rdata;
            end
        end
        if (!acked) check("ack_timeout", 32'd0, 32'd1);
        iomem_valid = 1'b0;
        iomem_wstrb = 4'd0;
        tick();
        check("ready_one_cycle", {31'd0, iomem_ready}, 32'd0);
    endtask

    logic [31:0] rd;
    int          rcount;

    initial begin
        reset = 1'b1; iomem_valid = 1'b0; iomem_wstrb = 4'd0;
        iomem_addr = '0; iomem_wdata = '0; gpio_in = 8'h00;
        repeat (3) tick();
        check("rst_ready", {31'd0, iomem_ready}, 32'd0);
        check("rst_rdata", iomem_rdata, 32'd0);
        check("rst_out", {24'd0, gpio_out}, 32'd0);
        check("rst_oe", {24'd0, gpio_oe}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        reset = 1'b0;
        tick();

        bus(8'h00, 4'b0000, 32'd0, rd); check("rd_out_rst", rd, 32'd0);
        bus(8'h04, 4'b0000, 32'd0, rd); check("rd_dir_rst", rd, 32'd0);
        bus(8'h1C, 4'b0000, 32'd0, rd); check("rd_status_rst", rd, 32'd0);

        // Address just past the window must never be acknowledged
        iomem_valid = 1'b1; iomem_addr = BASE + 32'h100; iomem_wstrb = 4'd0;
        rcount = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (iomem_ready) rcount++;
        end
        iomem_valid = 1'b0;
        check("miss_no_ready", rcount, 32'd0);

        bus(8'h00, 4'b0001, 32'h0000_00A5, rd); check("out_wr", {24'd0, gpio_out}, 32'hA5);
        bus(8'h0C, 4'b0001, 32'h0000_000A, rd); check("out_set", {24'd0, gpio_out}, 32'hAF);
        bus(8'h10, 4'b0001, 32'h0000_0080, rd); check("out_clr", {24'd0, gpio_out}, 32'h2F);
        bus(8'h14, 4'b0001, 32'h0000_00FF, rd); check("out_tog", {24'd0, gpio_out}, 32'hD0);
        bus(8'h00, 4'b0010, 32'h0000_FFFF, rd); check("out_hi_lane", {24'd0, gpio_out}, 32'hD0);
        bus(8'h00, 4'b0000, 32'd0, rd);         check("rd_out", rd, 32'hD0);
        bus(8'h0C, 4'b0000, 32'd0, rd);         check("rd_set_zero", rd, 32'd0);
        bus(8'h04, 4'b1111, 32'h0000_003C, rd); check("dir_oe", {24'd0, gpio_oe}, 32'h3C);

        // Valid held for six cycles: ready toggles 0,1,0,1,0,1
        iomem_valid = 1'b1; iomem_addr = BASE; iomem_wstrb = 4'd0;
        check("hold_r0", {31'd0, iomem_ready}, 32'd0);
        for (int i = 1; i < 6; i++) begin
            tick();
            check("hold_ready", {31'd0, iomem_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
            check("hold_rdata", iomem_rdata, (i % 2 == 1) ? 32'hD0 : 32'd0);
        end
        iomem_valid = 1'b0;
        tick();

        bus(8'h18, 4'b0001, 32'h0000_0008, rd);
        gpio_in = 8'h08;
        tick(); check("edge_irq_c1", {31'd0, irq}, 32'd0);
        tick(); check("edge_irq_c2", {31'd0, irq}, 32'd0);
        tick(); check("edge_irq_c3", {31'd0, irq}, 32'd1);
        bus(8'h08, 4'b0000, 32'd0, rd); check("rd_in", rd, 32'h08);
        bus(8'h1C, 4'b0000, 32'd0, rd); check("rd_status", rd, 32'h08);
        bus(8'h1C, 4'b0001, 32'h0000_0008, rd); check("w1c_irq", {31'd0, irq}, 32'd0);

        bus(8'h20, 4'b0001, 32'h0000_0008, rd);
        gpio_in = 8'h00;
        repeat (3) tick();
        check("fall_irq", {31'd0, irq}, 32'd1);
        bus(8'h1C, 4'b0000, 32'd0, rd); check("fall_status", rd, 32'h08);

        // Rising edge lands on the same clock as a W1C of that bit
        bus(8'h20, 4'b0001, 32'h0000_0000, rd);
        bus(8'h1C, 4'b0001, 32'h0000_0008, rd); check("pre_race_irq", {31'd0, irq}, 32'd0);
        gpio_in = 8'h08;
        tick();
        tick();
        bus(8'h1C, 4'b0001, 32'h0000_0008, rd);
        check("race_irq", {31'd0, irq}, 32'd1);
        bus(8'h1C, 4'b0000, 32'd0, rd); check("race_status", rd, 32'h08);

        // Reset arriving with a live write request
        iomem_valid = 1'b1; iomem_addr = BASE; iomem_wstrb = 4'b0001;
        iomem_wdata = 32'h55; reset = 1'b1;
        tick();
        check("midrst_ready", {31'd0, iomem_ready}, 32'd0);
        check("midrst_out", {24'd0, gpio_out}, 32'd0);
        check("midrst_oe", {24'd0, gpio_oe}, 32'd0);
        check("midrst_irq", {31'd0, irq}, 32'd0);
        iomem_valid = 1'b0; iomem_wstrb = 4'd0; reset = 1'b0;
        tick();
        bus(8'h00, 4'b0000, 32'd0, rd); check("postrst_out", rd, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
